// File: rtl/div_seq_param.sv
// Sequential restoring divider, one quotient bit per clock, with start/busy/done handshake.
// Optional two's-complement mode is enabled by defining DIV_SIGNED_EN (adds the signed_op port).
module div_seq_param #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               zero_div;
  logic               accept;
  logic               last_iter;
  logic               signed_mode;
  logic               neg_quo;
  logic               neg_rem;
  logic [WIDTH-1:0]   rem_w;
  logic [WIDTH-1:0]   quo_w;
  logic [WIDTH-1:0]   dvs_w;
  logic [WIDTH:0]     diff;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic en);
    logic signed [WIDTH-1:0] neg;
    neg = -v;
    return (en && v[WIDTH-1]) ? $unsigned(neg) : $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

`ifdef DIV_SIGNED_EN
  assign signed_mode = signed_op;
`else
  assign signed_mode = 1'b0;
`endif

  assign accept    = start && (state != CALC);
  assign last_iter = (cnt == CNT_LAST);
  // Partial remainder fits in WIDTH+1 bits; the top bit of the difference is the borrow.
  assign diff      = {rem_w, quo_w[WIDTH-1]} - {1'b0, dvs_w};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = accept ? CALC : IDLE;
      CALC:       if (zero_div || last_iter) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      cnt         <= '0;
      zero_div    <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (accept) begin
        busy     <= 1'b1;
        cnt      <= '0;
        zero_div <= (divisor == '0);
      end else if (state == CALC) begin
        if (zero_div) begin
          // The raw dividend was parked in quo_w for this case.
          busy        <= 1'b0;
          done        <= 1'b1;
          div_by_zero <= 1'b1;
          quotient    <= '1;
          remainder   <= quo_w;
        end else if (last_iter) begin
          busy        <= 1'b0;
          done        <= 1'b1;
          div_by_zero <= 1'b0;
          quotient    <= apply_sign(quo_w, neg_quo);
          remainder   <= apply_sign(rem_w, neg_rem);
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Working registers carry data only and need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_w   <= '0;
      quo_w   <= (divisor == '0) ? dividend : magnitude(dividend, signed_mode);
      dvs_w   <= magnitude(divisor, signed_mode);
      neg_quo <= signed_mode && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_rem <= signed_mode && dividend[WIDTH-1];
    end else if (state == CALC && !zero_div && !last_iter) begin
      if (!diff[WIDTH]) begin
        rem_w <= diff[WIDTH-1:0];
        quo_w <= {quo_w[WIDTH-2:0], 1'b1};
      end else begin
        rem_w <= {rem_w[WIDTH-2:0], quo_w[WIDTH-1]};
        quo_w <= {quo_w[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_div_seq_param.sv
// Bench for div_seq_param (WIDTH=16): directed vectors, handshake corner cases and random
// operands compared against a plain-arithmetic reference model.
module tb_div_seq_param;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
`ifdef DIV_SIGNED_EN
  logic         signed_op;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  div_seq_param #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef DIV_SIGNED_EN
    .signed_op   (signed_op),
`endif
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: truncating division from integer arithmetic; signed uses SV's own / and %.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z);
    longint sa;
    longint sb;
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = W'(sa / sb);
      r = W'(sa % sb);
      z = 1'b0;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endfunction

  // Called #1 after an edge; the next edge accepts. poke>0 pulses start (9/3) that many
  // edges after acceptance. Returns the results and the number of edges until done.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input int poke, output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z, output int lat, output logic busy_after,
                         output logic overlap);
    logic seen;
    dividend = a;
    divisor  = b;
`ifdef DIV_SIGNED_EN
    signed_op = s;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    busy_after = busy;
    overlap    = 1'b0;
    start      = 1'b0;
    lat        = 0;
    seen       = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (lat == poke && poke > 0) begin
        start = 1'b1; dividend = W'(9); divisor = W'(3);
      end else begin
        start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
      end
      @(posedge clk); #1;
      lat++;
      if (busy && done) overlap = 1'b1;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    if (!seen) begin
      errors++;
      $display("FAIL timeout: done not seen, got 0 expected 1");
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
  endtask

  task automatic run_and_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic s, input int poke, input logic [W-1:0] eq,
                               input logic [W-1:0] er, input logic ez);
    logic [W-1:0] q, r;
    logic z, ba, ov;
    int lat;
    run_div(a, b, s, poke, q, r, z, lat, ba, ov);
    check({tag, " quotient"}, 64'(q), 64'(eq));
    check({tag, " remainder"}, 64'(r), 64'(er));
    check({tag, " div_by_zero"}, 64'(z), 64'(ez));
    check({tag, " latency"}, 64'(lat), (b == 0) ? 64'd1 : 64'(W + 1));
    check({tag, " busy_done_overlap"}, 64'(ov), 64'd0);
    if (b != 0) check({tag, " busy_after_accept"}, 64'(ba), 64'd1);
  endtask

  initial begin
    logic [W-1:0] a, b, eq, er;
    logic s, ez;
    int done_cnt;

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
`ifdef DIV_SIGNED_EN
    signed_op = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset quotient", 64'(quotient), 64'd0);
    check("reset remainder", 64'(remainder), 64'd0);
    check("reset div_by_zero", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    vecs.push_back('{16'd100,  16'd7,    1'b0, 16'd14,   16'd2,    1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0});
    vecs.push_back('{16'h0003, 16'hFFFF, 1'b0, 16'h0000, 16'h0003, 1'b0});
    vecs.push_back('{16'h04D2, 16'h0000, 1'b0, 16'hFFFF, 16'h04D2, 1'b1});
    vecs.push_back('{16'h0000, 16'h0005, 1'b0, 16'h0000, 16'h0000, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'h0000, 1'b0});
    vecs.push_back('{16'hFFFE, 16'h8000, 1'b0, 16'h0001, 16'h7FFE, 1'b0});
`ifdef DIV_SIGNED_EN
    vecs.push_back('{16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0});
    vecs.push_back('{16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0});
    vecs.push_back('{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0});
    vecs.push_back('{16'hFFF9, 16'h0000, 1'b1, 16'hFFFF, 16'hFFF9, 1'b1});
`endif
    foreach (vecs[i])
      run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, 0,
                    vecs[i].q, vecs[i].r, vecs[i].z);

    // Start pulse mid-divide is ignored; start in the done cycle is accepted.
    run_and_check("ignore_busy", 16'd100, 16'd7, 1'b0, 5, 16'd14, 16'd2, 1'b0);
    run_and_check("back_to_back", 16'd9, 16'd3, 1'b0, 0, 16'd3, 16'd0, 1'b0);
    @(posedge clk); #1;
    check("done one cycle", 64'(done), 64'd0);
    check("results held", 64'(quotient), 64'd3);

    // Reset in the middle of a divide.
    dividend = 16'd100; divisor = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst quotient", 64'(quotient), 64'd0);
    check("midrst remainder", 64'(remainder), 64'd0);
    check("midrst div_by_zero", 64'(div_by_zero), 64'd0);
    done_cnt = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("midrst no done", 64'(done_cnt), 64'd0);

    for (int n = 0; n < 60; n++) begin
      a = W'($urandom);
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = '1;
        default: b = W'($urandom);
      endcase
`ifdef DIV_SIGNED_EN
      s = 1'($urandom_range(0, 1));
      if (n % 10 == 0) begin a = 16'h8000; b = 16'hFFFF; end
`else
      s = 1'b0;
`endif
      model(a, b, s, eq, er, ez);
      run_and_check($sformatf("rand%0d", n), a, b, s, 0, eq, er, ez);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
